sel_mux_pipe: RTL and testbench
===============================

# sel_mux_pipe

Parametrised N-way one-hot word selector with a registered output and a 2-entry valid/ready buffer. It replaces the fixed 4-input combinational selectors in datapath paths that need a pipeline register, such as forwarding and result-select stages that cross a stall boundary. Each accepted beat latches the selected word. With the check feature compiled in, the block also flags select vectors that are not one-hot.

## Interface
Parameters:
- `WIDTH`, 32: data word width in bits.
- `N`, 4: number of input channels; legal range 2..16.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `in_data` in N*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `sel` in N: one-hot channel select; bit i selects channel i.
- `in_valid` in 1: upstream beat present.
- `in_ready` out 1: block can accept a beat this cycle.
- `out_data` out WIDTH: head-of-buffer word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream consumes the head this cycle.
- `sel_err` out 1: one-cycle pulse indicating an illegal select was accepted.
- `err_count` out 8: saturating count of illegal selects.

## Operation
- Accept occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Select decode, evaluated at accept:
  - `sel` exactly one-hot at bit i: the stored word is channel i.
  - `sel` all-zero or multi-hot: the stored word is channel 0.
  - The block never ORs channels together.
- Buffer states:
  - EMPTY: `out_valid=0`, `in_ready=1`.
  - ONE: `out_valid=1`, `in_ready=1`.
  - FULL: `out_valid=1`, `in_ready=0`.
- Transitions:
  - Accept only: EMPTY→ONE, ONE→FULL.
  - Pop only: FULL→ONE, ONE→EMPTY.
  - Accept and pop together in ONE: stay in ONE; the new word becomes the head.
  - In FULL with `out_ready=1`: pop only, since `in_ready=0`. The block returns to ONE, and `in_ready=1` the next cycle.
- Ordering is strict FIFO. Words are not dropped, duplicated or reordered.
- `in_ready` depends only on registered state, never combinationally on `out_ready`.
- `out_data` is held stable while `out_valid=1 && out_ready=0`.
- Reset values, all forced in any cycle `RST=1` regardless of the other inputs:
  - state EMPTY, `out_valid=0`, `out_data=0`, `in_ready=0`.
  - `sel_err=0`, `err_count=0`.
- `in_ready` rises the first cycle after `RST` deasserts.
- Buffered beats are discarded on reset mid-operation.
- Inputs are ignored while `RST=1`.

## Timing
- Latency: a beat accepted at edge t into EMPTY appears with `out_valid=1` from edge t until it is popped, i.e. visible in the cycle after the accept cycle.
- Throughput: one beat per cycle sustained when `out_ready=1`.
- Stall recovery: if `out_ready` stays low, at most 2 beats are absorbed. The head is still consumed in the first cycle `out_ready` returns high.
- `sel_err` is registered. It pulses high for exactly the one cycle after an accept with an illegal `sel`. Back-to-back illegal accepts produce back-to-back pulses.
- `err_count` increments on the same edge that `sel_err` is set. It saturates at 255, with no wrap.

## Configuration
- Macro: `SEL_MUX_PIPE_ONEHOT_CHECK_EN`.
- Defined: one-hot checking, the `sel_err` pulse and the `err_count` register are built as described above.
- Undefined:
  - No check logic or counter is synthesised.
  - `sel_err` and `err_count` are tied to 0. The ports still exist.
  - Data-path behaviour, including the channel-0 default for illegal selects, is identical in both builds.

## Test plan
- **Reset:** hold `RST=1` for 3 cycles with `in_valid=1`.
  - Required: `out_valid=0`, `out_data=0`, `in_ready=0`, `err_count=0` throughout.
  - Required: `in_ready=1` the first cycle after release.
- **Streaming (N=4, WIDTH=32):** channels {0x11, 0x22, 0x33, 0x44}, sel sequence 0001, 0010, 0100, 1000, `out_ready=1`.
  - Required: outputs 0x11, 0x22, 0x33, 0x44 on consecutive cycles, one cycle after each accept.
- **Backpressure:** `out_ready=0`, push 3 beats A, B, C.
  - Required: A and B accepted; `in_ready=0` during the third attempt; C is held off upstream.
  - Raise `out_ready`. Required: A, B, C delivered in order.
- **Simultaneous push and pop in ONE:** hold occupancy at 1 for 5 cycles.
  - Required: `in_ready` stays 1 and `out_valid` stays 1.
- **Illegal select (check build):** send sel 0000, then 0110.
  - Required: both outputs equal channel 0.
  - Required: `sel_err` high on 2 consecutive cycles; `err_count=2`.
  - Then send 300 illegal beats. Required: `err_count=255`.
- **Illegal select (non-check build):** same stimulus.
  - Required: identical data output; `sel_err=0` and `err_count=0` always.

Source files
------------

// File: rtl/sel_mux_pipe.sv
// N-way one-hot word selector feeding a 2-entry valid/ready output buffer.
// Define SEL_MUX_PIPE_ONEHOT_CHECK_EN to build the illegal-select pulse and counter.
module sel_mux_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err,
  output logic [7:0]         err_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                  state, state_nxt;
  logic [N-1:0][WIDTH-1:0] chan;
  logic [WIDTH-1:0]        word, head_q, tail_q;
  logic                    onehot, acc, pop, rdy_q;
  logic                    ld_head, ld_tail, shift;

  for (genvar g = 0; g < N; g++) begin : g_chan
    assign chan[g] = in_data[g*WIDTH +: WIDTH];
  end

  assign onehot = (sel != '0) && ((sel & (sel - {{(N-1){1'b0}}, 1'b1})) == '0);

  // Illegal selects fall back to channel 0; channels are never ORed.
  always_comb begin
    word = chan[0];
    for (int i = 1; i < N; i++)
      if (onehot && sel[i]) word = chan[i];
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = head_q;
  assign acc       = in_valid && rdy_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    ld_head   = 1'b0;
    ld_tail   = 1'b0;
    shift     = 1'b0;
    case (state)
      EMPTY: if (acc) begin
        state_nxt = ONE;
        ld_head   = 1'b1;
      end
      ONE: begin
        if (acc && pop) ld_head = 1'b1;
        else if (acc) begin
          state_nxt = FULL;
          ld_tail   = 1'b1;
        end else if (pop) state_nxt = EMPTY;
      end
      FULL: if (pop) begin
        state_nxt = ONE;
        shift     = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Ready is registered from next state so it never follows out_ready combinationally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= EMPTY;
      rdy_q  <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != FULL);
      if (ld_head)    head_q <= word;
      else if (shift) head_q <= tail_q;
      if (ld_tail)    tail_q <= word;
    end
  end

`ifdef SEL_MUX_PIPE_ONEHOT_CHECK_EN
  logic       err_q;
  logic [7:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= acc && !onehot;
      if (acc && !onehot && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign sel_err   = err_q;
  assign err_count = cnt_q;
`else
  assign sel_err   = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed bench for sel_mux_pipe with a queue-based reference model checked every cycle.
module tb_sel_mux_pipe;

`ifdef SEL_MUX_PIPE_ONEHOT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [127:0] in_data = {32'h44, 32'h33, 32'h22, 32'h11};
  logic [3:0]  sel = 4'b0001;
  logic        in_valid = 1'b1;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sel_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  logic [31:0] popped[$];
  bit          m_rdy, m_err, m_zero;
  int          m_cnt;

  sel_mux_pipe #(.WIDTH(32), .N(4)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [127:0] d, input logic [3:0] s);
    int k = 0;
    if ($countones(s) == 1)
      for (int i = 0; i < 4; i++) if (s[i]) k = i;
    return d[k*32 +: 32];
  endfunction

  // Reference model: bounded queue of depth 2, ready when fewer than two are held.
  always @(posedge CLK) begin : model
    bit acc, pop;
    if (RST) begin
      mq.delete();
      m_rdy = 0; m_err = 0; m_cnt = 0; m_zero = 1;
    end else begin
      acc = in_valid && m_rdy;
      pop = (mq.size() > 0) && out_ready;
      if (pop) popped.push_back(mq.pop_front());
      if (acc) begin
        mq.push_back(exp_word(in_data, sel));
        m_zero = 0;
      end
      m_rdy = (mq.size() < 2);
      m_err = CHK_EN && acc && ($countones(sel) != 1);
      if (m_err && m_cnt != 255) m_cnt++;
    end
    #1;
    chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
    chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    if (m_zero) chk("cyc_out_data_zero", out_data, 32'd0);
    else if (mq.size() > 0) chk("cyc_out_data", out_data, mq[0]);
    chk("cyc_sel_err", {31'd0, sel_err}, {31'd0, m_err});
    chk("cyc_err_count", {24'd0, err_count}, m_cnt[31:0]);
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [3:0] s);
    int t = 0;
    in_valid = 1'b1;
    sel = s;
    while (!in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held three cycles with in_valid high
    repeat (3) begin
      @(negedge CLK);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);
    end
    RST = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming, one beat per cycle
    out_ready = 1'b1;
    popped.delete();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      sel = 4'b0001 << k;
      @(negedge CLK);
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data", out_data, 32'h11 * (k + 1));
    end
    in_valid = 1'b0;
    repeat (2) @(negedge CLK);
    chk("stream_pop_count", popped.size(), 32'd4);
    for (int k = 0; k < 4 && k < popped.size(); k++)
      chk("stream_pop_word", popped[k], 32'h11 * (k + 1));

    // Backpressure: A and B absorbed, C held off
    popped.delete();
    out_ready = 1'b0;
    send(4'b0001);
    send(4'b0010);
    in_valid = 1'b1;
    sel = 4'b0100;
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    @(negedge CLK);
    chk("bp_in_ready_hold", {31'd0, in_ready}, 32'd0);
    chk("bp_head_a", out_data, 32'h11);
    out_ready = 1'b1;
    @(negedge CLK);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("bp_head_b", out_data, 32'h22);
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("bp_pop_count", popped.size(), 32'd3);
    for (int k = 0; k < 3 && k < popped.size(); k++)
      chk("bp_order", popped[k], 32'h11 * (k + 1));

    // Occupancy held at one with simultaneous push and pop
    send(4'b0001);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      sel = 4'b0001 << (k % 4);
      @(negedge CLK);
      chk("one_in_ready", {31'd0, in_ready}, 32'd1);
      chk("one_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge CLK);

    // Illegal selects fall back to channel 0
    send(4'b0000);
    chk("ill_zero_data", out_data, 32'h11);
    chk("ill_zero_err", {31'd0, sel_err}, {31'd0, CHK_EN});
    send(4'b0110);
    chk("ill_multi_data", out_data, 32'h11);
    chk("ill_multi_err", {31'd0, sel_err}, {31'd0, CHK_EN});
    chk("ill_count2", {24'd0, err_count}, CHK_EN ? 32'd2 : 32'd0);
    in_valid = 1'b1;
    sel = 4'b0011;
    repeat (300) @(negedge CLK);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("ill_count_sat", {24'd0, err_count}, CHK_EN ? 32'd255 : 32'd0);
    chk("ill_err_drop", {31'd0, sel_err}, 32'd0);

    // Reset mid-operation discards buffered beats
    out_ready = 1'b0;
    send(4'b0100);
    send(4'b1000);
    RST = 1'b1;
    in_valid = 1'b1;
    @(negedge CLK);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_count", {24'd0, err_count}, 32'd0);
    RST = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("mid_rel_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rel_valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
